// File: rtl/controlador_autenticacao_pkg.sv
// Shared types and constants for the authentication controller.
// Holds the FSM state encoding, access-level constants, code width and
// the priority encoder that maps comparator outputs to a grant level.
package controlador_autenticacao_pkg;

  localparam int unsigned COD_W   = 6;
  localparam int unsigned AUT_W   = 3;
  localparam int unsigned NIVEL_W = 2;

  localparam logic [NIVEL_W-1:0] NIVEL_NENHUM = 2'd0;
  localparam logic [NIVEL_W-1:0] NIVEL_1      = 2'd1;
  localparam logic [NIVEL_W-1:0] NIVEL_2      = 2'd2;
  localparam logic [NIVEL_W-1:0] NIVEL_3      = 2'd3;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ESPERA    = 3'd1,
    CONCEDIDO = 3'd2,
    NEGADO    = 3'd3,
    BLOQUEIO  = 3'd4
  } estado_t;

  // Highest asserted AUT line wins.
  function automatic logic [NIVEL_W-1:0] codifica_nivel(input logic [AUT_W-1:0] aut);
    logic [NIVEL_W-1:0] nivel;
    if (aut[2])      nivel = NIVEL_3;
    else if (aut[1]) nivel = NIVEL_2;
    else if (aut[0]) nivel = NIVEL_1;
    else             nivel = NIVEL_NENHUM;
    return nivel;
  endfunction

endpackage

// File: rtl/controlador_autenticacao_contador.sv
// Down counter shared by the settle, lockout and grant timers.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   carga     - load valor (has priority over habilita)
//   valor     - load value
//   habilita  - decrement by one, stops at zero
//   zero_c    - combinational flag, count is zero
module contador_descendente #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carga,
  input  logic [W-1:0] valor,
  input  logic         habilita,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (carga) begin
      cnt <= valor;
    end else if (habilita && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/controlador_autenticacao.sv
// Authentication controller: latches a user code, presents it to the
// external comparator, samples the AUT result after a settle time and
// grants access at a priority-encoded level, counting consecutive
// failures and enforcing a timed lockout.
// Optional build macro AUT_TIMEOUT_EN: grants expire after GRANT_CYCLES.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   codigo     - user code {A..F}, A = bit 5
//   confirmar  - one-cycle request to evaluate codigo
//   sair       - one-cycle request to end an active grant
//   aut        - comparator outputs {AUT3,AUT2,AUT1}
//   cod_out    - registered code driven to the comparator
//   acesso     - access granted
//   nivel      - granted level (0 none, 1..3)
//   negado     - one-cycle pulse on a non-locking failure
//   bloqueado  - lockout active
//   falhas     - consecutive failure count
//   ocupado    - controller not idle
module controlador_autenticacao
  import controlador_autenticacao_pkg::*;
#(
  parameter int unsigned MAX_TENT     = 3,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter int unsigned SETTLE       = 1,
  parameter int unsigned GRANT_CYCLES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COD_W-1:0]                codigo,
  input  logic                            confirmar,
  input  logic                            sair,
  input  logic [AUT_W-1:0]                aut,
  output logic [COD_W-1:0]                cod_out,
  output logic                            acesso,
  output logic [NIVEL_W-1:0]              nivel,
  output logic                            negado,
  output logic                            bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0]   falhas,
  output logic                            ocupado
);

  localparam int unsigned FALHAS_W = $clog2(MAX_TENT + 1);
  localparam int unsigned MAX_SL   = (SETTLE > LOCK_CYCLES) ? SETTLE : LOCK_CYCLES;
  localparam int unsigned CNT_MAX  = (MAX_SL > GRANT_CYCLES) ? MAX_SL : GRANT_CYCLES;
  // Counter is loaded with N-1 so that zero marks the last cycle of a phase.
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  estado_t estado, estado_prox;

  logic [COD_W-1:0]    cod_d;
  logic                acesso_d;
  logic [NIVEL_W-1:0]  nivel_d;
  logic                negado_d;
  logic                bloqueado_d;
  logic [FALHAS_W-1:0] falhas_d;
  logic                ocupado_d;

  logic                cnt_carga;
  logic [CNT_W-1:0]    cnt_valor;
  logic                cnt_hab;
  logic                cnt_zero;

  logic                aut_ok;
  logic                ultima_falha;

  assign aut_ok       = (aut != '0);
  assign ultima_falha = (falhas == FALHAS_W'(MAX_TENT - 1));

  contador_descendente #(.W(CNT_W)) u_contador (
    .clk      (clk),
    .rst      (rst),
    .carga    (cnt_carga),
    .valor    (cnt_valor),
    .habilita (cnt_hab),
    .zero_c   (cnt_zero)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= OCIOSO;
      cod_out   <= '0;
      acesso    <= 1'b0;
      nivel     <= NIVEL_NENHUM;
      negado    <= 1'b0;
      bloqueado <= 1'b0;
      falhas    <= '0;
      ocupado   <= 1'b0;
    end else begin
      estado    <= estado_prox;
      cod_out   <= cod_d;
      acesso    <= acesso_d;
      nivel     <= nivel_d;
      negado    <= negado_d;
      bloqueado <= bloqueado_d;
      falhas    <= falhas_d;
      ocupado   <= ocupado_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO: begin
        if (confirmar) estado_prox = ESPERA;
      end
      ESPERA: begin
        if (cnt_zero) begin
          if (aut_ok)            estado_prox = CONCEDIDO;
          else if (ultima_falha) estado_prox = BLOQUEIO;
          else                   estado_prox = NEGADO;
        end
      end
      CONCEDIDO: begin
`ifdef AUT_TIMEOUT_EN
        if (sair || cnt_zero) estado_prox = OCIOSO;
`else
        if (sair) estado_prox = OCIOSO;
`endif
      end
      NEGADO: begin
        estado_prox = OCIOSO;
      end
      BLOQUEIO: begin
        if (cnt_zero) estado_prox = OCIOSO;
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase
  end

  // Next values of the registered outputs and counter control.
  always_comb begin
    cod_d       = cod_out;
    acesso_d    = acesso;
    nivel_d     = nivel;
    negado_d    = 1'b0;
    bloqueado_d = bloqueado;
    falhas_d    = falhas;
    ocupado_d   = (estado_prox != OCIOSO);
    cnt_carga   = 1'b0;
    cnt_valor   = '0;
    cnt_hab     = 1'b0;

    case (estado)
      OCIOSO: begin
        if (confirmar) begin
          cod_d     = codigo;
          cnt_carga = 1'b1;
          cnt_valor = CNT_W'(SETTLE - 1);
        end
      end
      ESPERA: begin
        if (cnt_zero) begin
          if (aut_ok) begin
            acesso_d = 1'b1;
            nivel_d  = codifica_nivel(aut);
            falhas_d = '0;
`ifdef AUT_TIMEOUT_EN
            cnt_carga = 1'b1;
            cnt_valor = CNT_W'(GRANT_CYCLES - 1);
`endif
          end else if (ultima_falha) begin
            bloqueado_d = 1'b1;
            falhas_d    = FALHAS_W'(MAX_TENT);
            cod_d       = '0;
            cnt_carga   = 1'b1;
            cnt_valor   = CNT_W'(LOCK_CYCLES - 1);
          end else begin
            falhas_d = falhas + FALHAS_W'(1);
            negado_d = 1'b1;
            cod_d    = '0;
          end
        end else begin
          cnt_hab = 1'b1;
        end
      end
      CONCEDIDO: begin
`ifdef AUT_TIMEOUT_EN
        if (sair || cnt_zero) begin
`else
        if (sair) begin
`endif
          acesso_d = 1'b0;
          nivel_d  = NIVEL_NENHUM;
          cod_d    = '0;
        end else begin
          cnt_hab = 1'b1;
        end
      end
      BLOQUEIO: begin
        if (cnt_zero) begin
          bloqueado_d = 1'b0;
          falhas_d    = '0;
        end else begin
          cnt_hab = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_controlador_autenticacao.sv
// Self-checking bench for controlador_autenticacao: directed scenarios plus
// randomized attempts checked against a transaction-level reference model.
module tb_controlador_autenticacao;

  localparam int unsigned MAX_TENT     = 3;
  localparam int unsigned LOCK_CYCLES  = 16;
  localparam int unsigned SETTLE       = 1;
  localparam int unsigned GRANT_CYCLES = 8;
  localparam int unsigned FW           = $clog2(MAX_TENT + 1);
`ifdef AUT_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    codigo;
  logic          confirmar;
  logic          sair;
  logic [2:0]    aut;
  logic [5:0]    cod_out;
  logic          acesso;
  logic [1:0]    nivel;
  logic          negado;
  logic          bloqueado;
  logic [FW-1:0] falhas;
  logic          ocupado;

  int n_total = 0;
  int n_ok    = 0;
  int falhas_m = 0;

  always #5 clk = ~clk;

  controlador_autenticacao #(
    .MAX_TENT     (MAX_TENT),
    .LOCK_CYCLES  (LOCK_CYCLES),
    .SETTLE       (SETTLE),
    .GRANT_CYCLES (GRANT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .codigo    (codigo),
    .confirmar (confirmar),
    .sair      (sair),
    .aut       (aut),
    .cod_out   (cod_out),
    .acesso    (acesso),
    .nivel     (nivel),
    .negado    (negado),
    .bloqueado (bloqueado),
    .falhas    (falhas),
    .ocupado   (ocupado)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_total++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
  endtask

  task automatic confere(input string tag, input logic [5:0] cod, input logic ac,
                         input logic [1:0] nv, input logic ng, input logic bl,
                         input int fl, input logic oc);
    verifica({tag, ".cod_out"},   32'(cod_out),   32'(cod));
    verifica({tag, ".acesso"},    32'(acesso),    32'(ac));
    verifica({tag, ".nivel"},     32'(nivel),     32'(nv));
    verifica({tag, ".negado"},    32'(negado),    32'(ng));
    verifica({tag, ".bloqueado"}, 32'(bloqueado), 32'(bl));
    verifica({tag, ".falhas"},    32'(falhas),    32'(fl));
    verifica({tag, ".ocupado"},   32'(ocupado),   32'(oc));
  endtask

  // Reference level: index of the highest set AUT bit, plus one.
  function automatic int nivel_esperado(input logic [2:0] a);
    int lvl = 0;
    for (int i = 0; i < 3; i++) if (a[i]) lvl = i + 1;
    return lvl;
  endfunction

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) begin
      confirmar = 1'b0;
      sair      = 1'($urandom_range(0, 1));
      aut       = 3'($urandom);
      codigo    = 6'($urandom);
      ciclo();
      confere("ocioso", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, falhas_m, 1'b0);
    end
    sair = 1'b0;
  endtask

  // One full attempt from idle: confirm, settle, result, and its aftermath.
  task automatic tentativa(input logic [5:0] code, input logic [2:0] aut_v, input int sair_at);
    int lvl;
    codigo    = code;
    confirmar = 1'b1;
    sair      = 1'b0;
    aut       = 3'($urandom);
    for (int s = 1; s <= int'(SETTLE); s++) begin
      ciclo();
      confirmar = 1'($urandom_range(0, 1));
      codigo    = 6'($urandom);
      aut       = (s == int'(SETTLE)) ? aut_v : 3'($urandom);
      confere("espera", code, 1'b0, 2'd0, 1'b0, 1'b0, falhas_m, 1'b1);
    end
    ciclo();
    confirmar = 1'b0;
    aut       = 3'($urandom);
    codigo    = 6'($urandom);
    if (aut_v != 3'd0) begin
      lvl = nivel_esperado(aut_v);
      falhas_m = 0;
      for (int g = 1; g <= 64; g++) begin
        confere("concedido", code, 1'b1, 2'(lvl), 1'b0, 1'b0, 0, 1'b1);
        sair      = (g == sair_at);
        confirmar = 1'($urandom_range(0, 1));
        ciclo();
        confirmar = 1'b0;
        sair      = 1'b0;
        aut       = 3'($urandom);
        if (g == sair_at || (TIMEOUT && g == int'(GRANT_CYCLES))) begin
          confere("fim_concessao", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b0);
          break;
        end
      end
    end else begin
      falhas_m++;
      if (falhas_m == int'(MAX_TENT)) begin
        for (int t = 0; t < int'(LOCK_CYCLES); t++) begin
          confere("bloqueio", 6'd0, 1'b0, 2'd0, 1'b0, 1'b1, MAX_TENT, 1'b1);
          confirmar = 1'($urandom_range(0, 1));
          sair      = 1'($urandom_range(0, 1));
          codigo    = 6'($urandom);
          ciclo();
        end
        confirmar = 1'b0;
        sair      = 1'b0;
        falhas_m  = 0;
        confere("fim_bloqueio", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b0);
      end else begin
        confere("negado", 6'd0, 1'b0, 2'd0, 1'b1, 1'b0, falhas_m, 1'b1);
        ciclo();
        confere("pos_negado", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, falhas_m, 1'b0);
      end
    end
  endtask

  task automatic reset_no_meio();
    logic [5:0] code;
    while (falhas_m != 2) tentativa(6'($urandom), 3'd0, 1);
    code      = 6'($urandom);
    codigo    = code;
    confirmar = 1'b1;
    ciclo();
    confirmar = 1'b0;
    confere("espera_pre_rst", code, 1'b0, 2'd0, 1'b0, 1'b0, 2, 1'b1);
    #2 rst = 1'b1;
    #1 confere("rst_assincrono", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b0);
    #2 rst = 1'b0;
    falhas_m = 0;
    ciclo();
    confere("pos_rst", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    codigo    = '0;
    confirmar = 1'b0;
    sair      = 1'b0;
    aut       = '0;
    #2 confere("reset", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ciclo();
    confere("apos_reset", 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b0);

    tentativa(6'b101010, 3'b111, 4);
    tentativa(6'($urandom), 3'b001, 2);
    tentativa(6'($urandom), 3'b010, 1);
    tentativa(6'($urandom), 3'b000, 1);
    ocioso(1);
    tentativa(6'($urandom), 3'b000, 1);
    tentativa(6'($urandom), 3'b000, 1);
`ifdef AUT_TIMEOUT_EN
    tentativa(6'($urandom), 3'b100, 1000);
    tentativa(6'($urandom), 3'b100, 3);
`endif
    reset_no_meio();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] a;
      a = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      tentativa(6'($urandom), a, int'($urandom_range(1, 12)));
      ocioso(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
